// File: rtl/shift_arbiter_if.sv
// Requester-side bus of the shared shifter: two request/response channels
// plus the shared result lines.
interface shift_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int NUM_W  = 8,
   parameter int OP_W   = 3
);
   logic [1:0]             rq_valid;
   logic [1:0]             rq_ready;
   logic [1:0][OP_W-1:0]   rq_op;
   logic [1:0][DATA_W-1:0] rq_data;
   logic [1:0][NUM_W-1:0]  rq_num;
   logic [1:0]             rq_cin;
   logic [1:0]             rs_valid;
   logic [1:0]             rs_ready;
   logic [DATA_W-1:0]      rs_data;
   logic                   rs_cout;

   modport slave (
      input  rq_valid, rq_op, rq_data, rq_num, rq_cin, rs_ready,
      output rq_ready, rs_valid, rs_data, rs_cout
   );

   modport master (
      output rq_valid, rq_op, rq_data, rq_num, rq_cin, rs_ready,
      input  rq_ready, rs_valid, rs_data, rs_cout
   );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one external combinational barrel shifter between
// two requesters; one operation in flight, operands and result registered.
module shift_arbiter #(
   parameter int DATA_W = 32,
   parameter int NUM_W  = 8,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   shift_arbiter_if.slave    bus,
   output logic [OP_W-1:0]   sh_op,
   output logic [DATA_W-1:0] sh_data,
   output logic [NUM_W-1:0]  sh_num,
   output logic              sh_cin,
   input  logic [DATA_W-1:0] sh_out,
   input  logic              sh_cout,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              gnt_q, gnt_d;
   logic [OP_W-1:0]   sh_op_q, sh_op_d;
   logic [DATA_W-1:0] sh_data_q, sh_data_d;
   logic [NUM_W-1:0]  sh_num_q, sh_num_d;
   logic              sh_cin_q, sh_cin_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic              rs_cout_q, rs_cout_d;
   logic [1:0]        rq_ready, rs_valid;
   logic              gnt_sel;

   // ptr holds the last requester served, so a tie goes to the other one
   assign gnt_sel = (bus.rq_valid[0] & bus.rq_valid[1]) ? ~ptr_q : bus.rq_valid[1];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      sh_op_d   = sh_op_q;
      sh_data_d = sh_data_q;
      sh_num_d  = sh_num_q;
      sh_cin_d  = sh_cin_q;
      rs_data_d = rs_data_q;
      rs_cout_d = rs_cout_q;
      rq_ready  = 2'b00;
      rs_valid  = 2'b00;
      case (state_q)
         IDLE: begin
            if (|bus.rq_valid) begin
               rq_ready[gnt_sel] = 1'b1;
               gnt_d     = gnt_sel;
               sh_op_d   = bus.rq_op[gnt_sel];
               sh_data_d = bus.rq_data[gnt_sel];
               sh_num_d  = bus.rq_num[gnt_sel];
               sh_cin_d  = bus.rq_cin[gnt_sel];
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            rs_data_d = sh_out;
            rs_cout_d = sh_cout;
            state_d   = RESP;
         end
         RESP: begin
            rs_valid[gnt_q] = 1'b1;
            if (bus.rs_ready[gnt_q]) begin
               ptr_d   = gnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b1;
         gnt_q     <= 1'b0;
         sh_op_q   <= '0;
         sh_data_q <= '0;
         sh_num_q  <= '0;
         sh_cin_q  <= 1'b0;
         rs_data_q <= '0;
         rs_cout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         sh_op_q   <= sh_op_d;
         sh_data_q <= sh_data_d;
         sh_num_q  <= sh_num_d;
         sh_cin_q  <= sh_cin_d;
         rs_data_q <= rs_data_d;
         rs_cout_q <= rs_cout_d;
      end
   end

   assign bus.rq_ready = rq_ready;
   assign bus.rs_valid = rs_valid;
   assign bus.rs_data  = rs_data_q;
   assign bus.rs_cout  = rs_cout_q;
   assign sh_op        = sh_op_q;
   assign sh_data      = sh_data_q;
   assign sh_num       = sh_num_q;
   assign sh_cin       = sh_cin_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: per-requester request/expected queues,
// a driver process, a response monitor, and directed scenarios.
module tb_shift_arbiter;
   localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, PASS = 3'd5;

   typedef struct { logic [2:0] op; logic [31:0] d; logic [7:0] n; logic c; } req_t;
   typedef struct { logic [31:0] d; logic c; } rsp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [2:0] sh_op; logic [31:0] sh_data, sh_out; logic [7:0] sh_num;
   logic sh_cin, sh_cout, busy;
   logic [1:0] en = 2'b00;
   int checks = 0, failures = 0;
   req_t rqq0[$], rqq1[$];
   rsp_t exq0[$], exq1[$];
   int acc_log[$];

   always #5 clk = ~clk;

   shift_arbiter_if #(.DATA_W(32), .NUM_W(8), .OP_W(3)) bus ();

   shift_arbiter #(.DATA_W(32), .NUM_W(8), .OP_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .sh_op(sh_op), .sh_data(sh_data), .sh_num(sh_num), .sh_cin(sh_cin),
      .sh_out(sh_out), .sh_cout(sh_cout), .busy(busy)
   );

   // external shifter stand-in
   function automatic logic [32:0] shf(logic [2:0] op, logic [31:0] d, logic [7:0] n, logic c);
      int k;
      logic [31:0] o;
      logic co;
      k = int'(n);
      case (op)
         LSL: begin
            o  = (k >= 32) ? 32'd0 : d << k;
            co = (k == 0) ? c : (k <= 32) ? d[32-k] : 1'b0;
         end
         LSR: begin
            o  = (k >= 32) ? 32'd0 : d >> k;
            co = (k == 0) ? c : (k <= 32) ? d[k-1] : 1'b0;
         end
         default: begin o = d; co = c; end
      endcase
      return {co, o};
   endfunction

   always_comb {sh_cout, sh_out} = shf(sh_op, sh_data, sh_num, sh_cin);

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send(int i, logic [2:0] op, logic [31:0] d, logic [7:0] n, logic c,
                       logic [31:0] ed, logic ec, bit expect_rsp);
      req_t r;
      rsp_t e;
      r.op = op; r.d = d; r.n = n; r.c = c;
      e.d = ed; e.c = ec;
      if (i == 0) begin rqq0.push_back(r); if (expect_rsp) exq0.push_back(e); end
      else begin rqq1.push_back(r); if (expect_rsp) exq1.push_back(e); end
   endtask

   // driver: acceptance sampled just before the edge, next head presented after it
   initial begin
      logic [1:0] acc;
      bus.rq_valid = 2'b00; bus.rq_op = '0; bus.rq_data = '0; bus.rq_num = '0;
      bus.rq_cin = 2'b00; bus.rs_ready = 2'b11;
      forever begin
         @(negedge clk); #3;
         acc = bus.rq_valid & bus.rq_ready & {2{rst_n}};
         if (acc[0]) acc_log.push_back(0);
         if (acc[1]) acc_log.push_back(1);
         @(posedge clk); #1;
         if (acc[0] && rqq0.size() > 0) void'(rqq0.pop_front());
         if (acc[1] && rqq1.size() > 0) void'(rqq1.pop_front());
         if (en[0] && rqq0.size() > 0) begin
            bus.rq_valid[0] = 1'b1; bus.rq_op[0] = rqq0[0].op; bus.rq_data[0] = rqq0[0].d;
            bus.rq_num[0] = rqq0[0].n; bus.rq_cin[0] = rqq0[0].c;
         end else bus.rq_valid[0] = 1'b0;
         if (en[1] && rqq1.size() > 0) begin
            bus.rq_valid[1] = 1'b1; bus.rq_op[1] = rqq1[0].op; bus.rq_data[1] = rqq1[0].d;
            bus.rq_num[1] = rqq1[0].n; bus.rq_cin[1] = rqq1[0].c;
         end else bus.rq_valid[1] = 1'b0;
      end
   end

   // monitor: pops and compares on every response handshake
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk); #3;
         if (rst_n) begin
            if (&bus.rs_valid) chk("rs_valid_onehot", 64'(bus.rs_valid), 64'd1);
            for (int i = 0; i < 2; i++) begin
               if (bus.rs_valid[i]) begin
                  if ((i == 0 ? exq0.size() : exq1.size()) == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_rsp req=%0d actual=rs_valid required=none", i);
                  end else if (bus.rs_ready[i]) begin
                     e = (i == 0) ? exq0.pop_front() : exq1.pop_front();
                     chk($sformatf("rs_data%0d", i), 64'(bus.rs_data), 64'(e.d));
                     chk($sformatf("rs_cout%0d", i), 64'(bus.rs_cout), 64'(e.c));
                  end
               end
            end
         end
      end
   end

   task automatic chk_zero(string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_rs_valid"}, 64'(bus.rs_valid), 64'd0);
      chk({tag, "_sh_op"}, 64'(sh_op), 64'd0);
      chk({tag, "_sh_data"}, 64'(sh_data), 64'd0);
      chk({tag, "_sh_num"}, 64'(sh_num), 64'd0);
      chk({tag, "_sh_cin"}, 64'(sh_cin), 64'd0);
      chk({tag, "_rs_data"}, 64'(bus.rs_data), 64'd0);
      chk({tag, "_rs_cout"}, 64'(bus.rs_cout), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 2'b00;
      rqq0.delete(); rqq1.delete(); exq0.delete(); exq1.delete(); acc_log.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
   endtask

   task automatic wait_acc(int i);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.rq_valid[i] && bus.rq_ready[i]) return;
      end
      checks++; failures++;
      $display("FAIL wait_acc%0d actual=timeout required=accept", i);
   endtask

   task automatic wait_rsv(int i);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.rs_valid[i]) return;
      end
      checks++; failures++;
      $display("FAIL wait_rsv%0d actual=timeout required=rs_valid", i);
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (exq0.size() == 0 && exq1.size() == 0 && rqq0.size() == 0 &&
             rqq1.size() == 0 && !busy) return;
      end
      checks++; failures++;
      $display("FAIL wait_idle actual=timeout required=drained");
   endtask

   initial begin
      int base;
      int exp_order[6];
      exp_order = '{0, 1, 0, 1, 0, 1};

      // 1: single op, latency and operand registers
      do_reset();
      en = 2'b11;
      send(0, LSL, 32'h1, 8'd4, 1'b0, 32'h10, 1'b0, 1);
      wait_acc(0);
      @(negedge clk);
      chk("t1_sh_op", 64'(sh_op), 64'(LSL));
      chk("t1_sh_data", 64'(sh_data), 64'h1);
      chk("t1_sh_num", 64'(sh_num), 64'd4);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_issue_rs_valid", 64'(bus.rs_valid), 64'd0);
      chk("t1_issue_rq_ready", 64'(bus.rq_ready), 64'd0);
      @(negedge clk);
      chk("t1_rs_valid", 64'(bus.rs_valid), 64'b01);
      chk("t1_rs_data", 64'(bus.rs_data), 64'h10);
      wait_idle();

      // 2: both valid from reset, strict alternation
      do_reset();
      send(0, LSR, 32'hF0, 8'd4, 1'b0, 32'hF, 1'b0, 1);
      send(1, LSL, 32'h1234, 8'd4, 1'b0, 32'h12340, 1'b0, 1);
      send(0, LSL, 32'hFFFF_FFFF, 8'd8, 1'b0, 32'hFFFF_FF00, 1'b1, 1);
      send(1, LSR, 32'h8000_0000, 8'd31, 1'b0, 32'h1, 1'b0, 1);
      send(0, LSR, 32'h1, 8'd1, 1'b0, 32'h0, 1'b1, 1);
      send(1, LSL, 32'h1, 8'd31, 1'b1, 32'h8000_0000, 1'b0, 1);
      en = 2'b11;
      wait_idle();
      chk("t2_ops", 64'(acc_log.size()), 64'd6);
      for (int k = 0; k < 6 && k < acc_log.size(); k++)
         chk($sformatf("t2_order%0d", k), 64'(acc_log[k]), 64'(exp_order[k]));

      // 3: stalled response stays stable and blocks new accepts
      bus.rs_ready[0] = 1'b0;
      send(0, LSL, 32'h8000_0003, 8'd1, 1'b1, 32'h6, 1'b1, 1);
      send(1, PASS, 32'hDEAD_BEEF, 8'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1);
      wait_rsv(0);
      base = acc_log.size();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_rs_valid", 64'(bus.rs_valid), 64'b01);
         chk("t3_rs_data", 64'(bus.rs_data), 64'h6);
         chk("t3_rs_cout", 64'(bus.rs_cout), 64'd1);
         chk("t3_rq_ready", 64'(bus.rq_ready), 64'd0);
      end
      chk("t3_no_accept", 64'(acc_log.size()), 64'(base));
      bus.rs_ready[0] = 1'b1;
      wait_idle();
      chk("t3_req1_served", 64'(acc_log[acc_log.size()-1]), 64'd1);

      // 4: carry path
      send(0, LSL, 32'h8000_0001, 8'd0, 1'b1, 32'h8000_0001, 1'b1, 1);
      send(0, LSL, 32'h4000_0000, 8'd1, 1'b0, 32'h8000_0000, 1'b0, 1);
      wait_idle();

      // 5: reset in ISSUE and in RESP
      do_reset();
      en = 2'b11;
      send(0, LSL, 32'h1, 8'd0, 1'b0, 32'h1, 1'b0, 1);
      wait_idle();
      send(0, LSR, 32'hAAAA_0000, 8'd0, 1'b1, 32'h0, 1'b0, 0);
      wait_acc(0);
      @(negedge clk);
      chk("t5_issue_busy", 64'(busy), 64'd1);
      chk("t5_issue_sh_data", 64'(sh_data), 64'hAAAA_0000);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("t5_issue_rst");
      rst_n = 1'b1;
      bus.rs_ready[0] = 1'b0;
      send(0, LSL, 32'hFF, 8'd4, 1'b1, 32'hFF0, 1'b0, 1);
      wait_rsv(0);
      chk("t5_resp_rs_data", 64'(bus.rs_data), 64'hFF0);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("t5_resp_rst");
      exq0.delete();
      rst_n = 1'b1;
      bus.rs_ready[0] = 1'b1;
      en = 2'b00;
      base = acc_log.size();
      send(0, LSL, 32'h5, 8'd2, 1'b0, 32'h14, 1'b0, 1);
      send(1, LSR, 32'h5, 8'd2, 1'b0, 32'h1, 1'b0, 1);
      en = 2'b11;
      wait_idle();
      chk("t5_ptr_first", 64'(acc_log[base]), 64'd0);

      // 6: withdrawn request never served
      do_reset();
      en = 2'b11;
      send(0, LSL, 32'h2, 8'd1, 1'b0, 32'h4, 1'b0, 1);
      wait_idle();
      en = 2'b00;
      send(1, LSR, 32'h80, 8'd7, 1'b0, 32'h1, 1'b0, 1);
      send(0, LSL, 32'h3, 8'd1, 1'b0, 32'h6, 1'b0, 0);
      en = 2'b11;
      @(negedge clk);
      chk("t6_rq_valid", 64'(bus.rq_valid), 64'b11);
      chk("t6_rq_ready", 64'(bus.rq_ready), 64'b10);
      en[0] = 1'b0;
      @(negedge clk);
      rqq0.delete();
      wait_idle();
      repeat (5) @(negedge clk);
      chk("t6_accepts", 64'(acc_log.size()), 64'd2);
      chk("t6_last", 64'(acc_log[acc_log.size()-1]), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end
endmodule
